// File: rtl/i2s_rx_sampler.sv
// I2S receive front end: synchronizes bclk/lrclk/sdin into clk, deserializes
// 16-bit MSB-first words and forwards the selected channel as single-cycle pulses.
module i2s_rx_sampler #(
  parameter int CHANNEL     = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bclk,
  input  logic        lrclk,
  input  logic        sdin,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        frame_error,
  output logic [1:0]  dbg_state
);

  // Handshake: sample/sample_valid is valid-only with no ready. sample is
  // stable between pulses, and each pulse lasts exactly one clk cycle.

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic CH_SEL = (CHANNEL != 0);

  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic bclk_s, lrclk_s, sdin_s, bclk_rise;

  logic bclk_prev_q, bclk_prev_d;
  logic rise_q, rise_d;
  logic lr_now_q, lr_now_d;
  logic lr_prev_q, lr_prev_d;
  logic din_q, din_d;
  logic lr_chg;

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] sr_q, sr_d;
  logic        ch_q, ch_d;
  logic [15:0] sample_q, sample_d;
  logic        sample_valid_q, sample_valid_d;
  logic        frame_error_q, frame_error_d;
  logic        complete;
  logic [15:0] word;

  // Synchronizers and the bclk edge detector.
  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], bclk};
    lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], lrclk};
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], sdin};
    bclk_s      = bclk_sync_q[SYNC_STAGES-1];
    lrclk_s     = lr_sync_q[SYNC_STAGES-1];
    sdin_s      = sd_sync_q[SYNC_STAGES-1];
    bclk_rise   = bclk_s & ~bclk_prev_q;
    bclk_prev_d = bclk_s;
    rise_d      = bclk_rise;
    lr_now_d    = bclk_rise ? lrclk_s : lr_now_q;
    din_d       = bclk_rise ? sdin_s : din_q;
    lr_prev_d   = bclk_rise ? lr_now_q : lr_prev_q;
  end

  assign lr_chg = (lr_now_q != lr_prev_q);

  // Word state machine; acts one cycle after each captured bclk rise.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    sr_d           = sr_q;
    ch_d           = ch_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    frame_error_d  = frame_error_q;
    complete       = 1'b0;
    word           = {sr_q[14:0], din_q};

    if (rise_q) begin
      case (state_q)
        HUNT: begin
          if (lr_chg) begin
            ch_d      = lr_now_q;
            bit_cnt_d = 5'd0;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          if (!lr_chg) begin
            sr_d      = word;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd15) begin
              complete = 1'b1;
              state_d  = HOLD;
            end
          end else begin
            // A word-select change here carries the LSB of a 16-slot word.
            if (bit_cnt_q == 5'd15) begin
              sr_d     = word;
              complete = 1'b1;
            end else begin
              frame_error_d = 1'b1;
            end
            ch_d      = lr_now_q;
            bit_cnt_d = 5'd0;
            state_d   = SHIFT;
          end
        end
        HOLD: begin
          if (lr_chg) begin
            ch_d      = lr_now_q;
            bit_cnt_d = 5'd0;
            state_d   = SHIFT;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end

    // ch_q is still the finishing word's channel when a restart coincides.
    if (complete && (ch_q == CH_SEL)) begin
      sample_d       = word;
      sample_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_q    <= '0;
      lr_sync_q      <= '0;
      sd_sync_q      <= '0;
      bclk_prev_q    <= 1'b0;
      rise_q         <= 1'b0;
      lr_now_q       <= 1'b0;
      lr_prev_q      <= 1'b0;
      din_q          <= 1'b0;
      state_q        <= HUNT;
      bit_cnt_q      <= 5'd0;
      sr_q           <= 16'd0;
      ch_q           <= 1'b0;
      sample_q       <= 16'd0;
      sample_valid_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      bclk_sync_q    <= bclk_sync_d;
      lr_sync_q      <= lr_sync_d;
      sd_sync_q      <= sd_sync_d;
      bclk_prev_q    <= bclk_prev_d;
      rise_q         <= rise_d;
      lr_now_q       <= lr_now_d;
      lr_prev_q      <= lr_prev_d;
      din_q          <= din_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      sr_q           <= sr_d;
      ch_q           <= ch_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      frame_error_q  <= frame_error_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign frame_error  = frame_error_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/i2s_rx_sampler.md
# i2s_rx_sampler

Front-end deserializer for the audio filter chain. It receives a standard I2S stream from the external ADC and synchronizes the asynchronous `bclk`, `lrclk` and `sdin` pins into the system clock domain. It extracts 16-bit signed words for one selected channel and presents each word with a single-cycle `sample_valid` pulse. The outputs connect directly to the biquad stage: `sample` drives `latest_sample` and `sample_valid` drives `trigger`.

## Interface
- `CHANNEL`, default 0: channel forwarded downstream. 0 = left (`lrclk` low), 1 = right (`lrclk` high).
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchronizer. Legal values are ≥ 2.
- `clk`  in  1  system clock. This is the only clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `bclk`  in  1  I2S bit clock from the ADC. Asynchronous to `clk`.
- `lrclk`  in  1  I2S word select. Changes on the falling edge of `bclk`.
- `sdin`  in  1  I2S serial data, MSB first. Changes on the falling edge of `bclk`.
- `sample`  out  16  last completed word for `CHANNEL`, two's complement.
- `sample_valid`  out  1  one-`clk` pulse; `sample` is new on this cycle.
- `frame_error`  out  1  sticky flag; set when a truncated word is seen.

## Operation
- **Synchronization:** each of `bclk`, `lrclk` and `sdin` passes through `SYNC_STAGES` flops. A registered copy of synced `bclk` produces `bclk_rise`, a one-cycle pulse on a 0→1 transition.
- **Sampling:** on each `bclk_rise`, capture synced `lrclk` as `lr_now` and synced `sdin` as `bit`.
- **Word-select change:** `lr_chg = (lr_now != lr_prev)`. `lr_prev` updates on every `bclk_rise`.
- **State machine**, with a 5-bit `bit_cnt`, a 16-bit shift register `sr`, and a word-channel register `ch`:
  - **HUNT** (reset state): ignores data. On a `bclk_rise` with `lr_chg`: set `ch=lr_now`, `bit_cnt=0`, go to SHIFT. This edge's bit is the previous word's LSB and is discarded.
  - **SHIFT**, on a `bclk_rise` without `lr_chg`: `sr={sr[14:0],bit}`, `bit_cnt++`. If `bit_cnt` becomes 16, the word is complete; go to HOLD.
  - **SHIFT**, on a `bclk_rise` with `lr_chg`:
    - If `bit_cnt==15`: shift in `bit` as the LSB and complete the word. This is the 16-bclk-slot case.
    - If `bit_cnt<15`: set `frame_error` and discard the word.
    - In either case, then restart: `ch=lr_now`, `bit_cnt=0`, stay in SHIFT.
  - **HOLD**: ignores padding bits (slots wider than 16 bclk are truncated to the 16 MSBs). On a `bclk_rise` with `lr_chg`: restart as above and go to SHIFT.
- **Completion:** when a word completes and `ch==CHANNEL`, register `sample<=completed word` and pulse `sample_valid`. Words for the other channel are dropped silently, and `sample` holds its value.
- `frame_error` clears only on `reset`.

## Timing
- **Reset values:** `sample=0`, `sample_valid=0`, `frame_error=0`. The state machine returns to HUNT, and `bit_cnt`, `sr`, `ch` and `lr_prev` are zeroed.
- **Reset mid-word:** the partial word is lost and no `sample_valid` is produced. The first output after reset is the first full word that begins after the first observed `lrclk` change.
- **Latency:** `sample_valid` rises `SYNC_STAGES+2` `clk` cycles after the `bclk` pin edge that carries the word's final bit. This is 4 cycles at the default depth. `sample_valid` lasts exactly 1 cycle.
- **Input constraint:** `bclk` high and low phases are each ≥ `SYNC_STAGES+1` `clk` periods. Slot width is 16 to 32 bclk per channel.
- **Output rate:** at most one `sample_valid` per I2S frame. Consecutive pulses are ≥ 32 bclk periods apart. This exceeds the downstream filter's 9-cycle processing window, so no backpressure input is needed.
- **Simultaneous events:** completion and restart on the same `lr_chg` edge both take effect in that cycle. The completion pulse is not lost.

## Test plan
- **Nominal 32-bclk frames, `CHANNEL=0`:** left = 0x1234, right = 0xBEEF → `sample_valid` once per frame with `sample`=0x1234; `frame_error`=0. The bench checks the 4-cycle latency from the final-bit bclk edge.
- **`CHANNEL=1`, 64-bclk frames:** right = 0x8001 followed by 16 padding ones → `sample`=0x8001 (−32767). Padding is ignored and `sample_valid` fires on the 16th data bit.
- **Startup mid-frame:** release reset halfway through a left word → no pulse for that partial word; the first `sample_valid` carries the next full left word (0x0F0F).
- **Short word:** `lrclk` toggles after 10 data bits → `frame_error`=1 and stays 1; the truncated word is not output; the following 16-bit word 0x7FFF is output normally.
- **Reset mid-word:** assert `reset` for 1 cycle during the bit-8 bclk period → outputs return to 0; no pulse until the next complete word, which is 0xA5A5.
- **Back-to-back frames:** 50 random frames at minimum bclk half-period (3 clk) → every left word is reproduced exactly, and the `sample_valid` count equals 50.
